// File: rtl/nco_pkg.sv
// Shared constants and types for the multi-channel NCO phase sequencer.
package nco_pkg;

   localparam logic CFG_SEL_FTW = 1'b0;
   localparam logic CFG_SEL_OFF = 1'b1;

   localparam logic [31:0] PHASE_INC = 32'h088F5C28;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } nco_state_e;

endpackage : nco_pkg

// File: rtl/nco_phase_seq_if.sv
// Config write port and angle stream of the NCO phase sequencer.
interface nco_phase_seq_if #(
   parameter int unsigned PHASE_W = 32,
   parameter int unsigned NCH     = 4
);
   localparam int unsigned CH_W = $clog2(NCH);

   logic               cfg_valid;
   logic               cfg_ready;
   logic [CH_W-1:0]    cfg_addr;
   logic               cfg_sel;
   logic [PHASE_W-1:0] cfg_data;
   logic               cfg_clr;

   logic [PHASE_W-1:0] angle_out;
   logic [CH_W-1:0]    angle_ch;
   logic               angle_valid;

   modport master (
      output cfg_valid, cfg_addr, cfg_sel, cfg_data, cfg_clr,
      input  cfg_ready, angle_out, angle_ch, angle_valid
   );

   modport slave (
      input  cfg_valid, cfg_addr, cfg_sel, cfg_data, cfg_clr,
      output cfg_ready, angle_out, angle_ch, angle_valid
   );

endinterface : nco_phase_seq_if

// File: rtl/nco_tick_div.sv
// Programmable sample-rate divider: one-cycle sample_tick every div_val+1 enabled clocks.
module nco_tick_div #(
   parameter int unsigned DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [DIV_W-1:0] div_val,
   output logic             sample_tick
);

   logic [DIV_W-1:0] cnt_q;

   // A count already past div_val keeps incrementing and wraps through zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         sample_tick <= 1'b0;
      end else if (enable) begin
         if (cnt_q == div_val) begin
            cnt_q       <= '0;
            sample_tick <= 1'b1;
         end else begin
            cnt_q       <= cnt_q + DIV_W'(1);
            sample_tick <= 1'b0;
         end
      end else begin
         sample_tick <= 1'b0;
      end
   end

endmodule : nco_tick_div

// File: rtl/nco_phase_seq.sv
// Time-multiplexed multi-channel phase accumulator with double-buffered FTW/offset,
// streaming one angle per clock for NCH clocks after each accepted sample tick.
module nco_phase_seq
   import nco_pkg::*;
#(
   parameter int unsigned PHASE_W = 32,
   parameter int unsigned NCH     = 4,
   parameter int unsigned DIV_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [DIV_W-1:0] div_val,
   nco_phase_seq_if.slave   bus,
   output logic             sample_tick,
   output logic             busy,
   output logic             overrun
);

   localparam int unsigned     CH_W    = $clog2(NCH);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

   nco_state_e         state_q;
   logic [CH_W-1:0]    ch_q;

   logic [PHASE_W-1:0] phase_q   [NCH];
   logic [PHASE_W-1:0] ftw_sh_q  [NCH];
   logic [PHASE_W-1:0] off_sh_q  [NCH];
   logic [PHASE_W-1:0] ftw_act_q [NCH];
   logic [PHASE_W-1:0] off_act_q [NCH];
   logic [NCH-1:0]     clr_pend_q;

   logic               cfg_ready_q;
   logic               angle_valid_q;
   logic [PHASE_W-1:0] angle_q;
   logic [CH_W-1:0]    angle_ch_q;

   logic               burst_last_c;
   logic               accept_c;
   logic               run_c;
   logic               cfg_fire_c;
   logic [CH_W-1:0]    nk_c;
   logic [PHASE_W-1:0] base_c;
   logic [PHASE_W-1:0] ftw_c;
   logic [PHASE_W-1:0] off_c;
   logic [PHASE_W-1:0] acc_c;
   logic [PHASE_W-1:0] ang_c;

   nco_tick_div #(.DIV_W(DIV_W)) u_tick_div (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .div_val     (div_val),
      .sample_tick (sample_tick)
   );

   // Next-cycle channel and its sum; on the accepting tick the just-committed
   // shadow values and any pending clear are folded in directly.
   always_comb begin
      burst_last_c = (state_q == BURST) && (ch_q == LAST_CH);
      accept_c     = sample_tick && ((state_q == IDLE) || burst_last_c);
      run_c        = accept_c || ((state_q == BURST) && !burst_last_c);
      cfg_fire_c   = bus.cfg_valid && cfg_ready_q;
      nk_c         = '0;
      base_c       = '0;
      ftw_c        = '0;
      off_c        = '0;
      if (!(accept_c || burst_last_c)) begin
         nk_c = ch_q + CH_W'(1);
      end
      if (accept_c) begin
         base_c = clr_pend_q[0] ? '0 : phase_q[0];
         ftw_c  = ftw_sh_q[0];
         off_c  = off_sh_q[0];
      end else begin
         base_c = phase_q[nk_c];
         ftw_c  = ftw_act_q[nk_c];
         off_c  = off_act_q[nk_c];
      end
      acc_c = base_c + ftw_c;
      ang_c = acc_c + off_c;
   end

   // FSM, registered outputs and overrun flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ch_q          <= '0;
         cfg_ready_q   <= 1'b1;
         angle_valid_q <= 1'b0;
         busy          <= 1'b0;
         angle_q       <= '0;
         angle_ch_q    <= '0;
         overrun       <= 1'b0;
      end else begin
         state_q       <= run_c ? BURST : IDLE;
         cfg_ready_q   <= !run_c;
         angle_valid_q <= run_c;
         busy          <= run_c;
         if (run_c) begin
            ch_q       <= nk_c;
            angle_q    <= ang_c;
            angle_ch_q <= nk_c;
         end
         if (sample_tick && !accept_c) begin
            overrun <= 1'b1;
         end
      end
   end

   // Accumulators, shadow/active parameter banks and clear-pending bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            phase_q[i]   <= '0;
            ftw_sh_q[i]  <= '0;
            off_sh_q[i]  <= '0;
            ftw_act_q[i] <= '0;
            off_act_q[i] <= '0;
         end
         clr_pend_q <= '0;
      end else begin
         if (accept_c) begin
            for (int i = 0; i < NCH; i++) begin
               ftw_act_q[i] <= ftw_sh_q[i];
               off_act_q[i] <= off_sh_q[i];
               if (clr_pend_q[i]) begin
                  phase_q[i] <= '0;
               end
            end
            clr_pend_q <= '0;
         end
         if (run_c) begin
            phase_q[nk_c] <= acc_c;
         end
         // A write coinciding with a tick lands in shadow only, for the next commit.
         if (cfg_fire_c) begin
            if (bus.cfg_sel == CFG_SEL_FTW) begin
               ftw_sh_q[bus.cfg_addr] <= bus.cfg_data;
            end else begin
               off_sh_q[bus.cfg_addr] <= bus.cfg_data;
            end
            if (bus.cfg_clr) begin
               clr_pend_q[bus.cfg_addr] <= 1'b1;
            end
         end
      end
   end

   assign bus.cfg_ready   = cfg_ready_q;
   assign bus.angle_out   = angle_q;
   assign bus.angle_ch    = angle_ch_q;
   assign bus.angle_valid = angle_valid_q;

endmodule : nco_phase_seq

// File: tb/tb_nco_phase_seq.sv
// Directed bench for nco_phase_seq with hand-computed expected angles.
module tb_nco_phase_seq;
   import nco_pkg::*;

   localparam int unsigned PHASE_W = 32;
   localparam int unsigned NCH     = 4;
   localparam int unsigned DIV_W   = 8;

   logic             clk     = 1'b0;
   logic             rst_n   = 1'b0;
   logic             enable  = 1'b0;
   logic [DIV_W-1:0] div_val = '0;
   logic             sample_tick;
   logic             busy;
   logic             overrun;

   int n_checks = 0;
   int n_errs   = 0;

   nco_phase_seq_if #(.PHASE_W(PHASE_W), .NCH(NCH)) bus ();

   nco_phase_seq #(.PHASE_W(PHASE_W), .NCH(NCH), .DIV_W(DIV_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .div_val     (div_val),
      .bus         (bus.slave),
      .sample_tick (sample_tick),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      enable        = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.cfg_clr   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Called at a negedge while cfg_ready is expected high.
   task automatic cfg_write(input logic [1:0] addr, input logic sel,
                            input logic [31:0] data, input logic clr);
      chk("cfg_ready_before_write", 32'(bus.cfg_ready), 32'd1);
      bus.cfg_valid = 1'b1;
      bus.cfg_addr  = addr;
      bus.cfg_sel   = sel;
      bus.cfg_data  = data;
      bus.cfg_clr   = clr;
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      bus.cfg_clr   = 1'b0;
   endtask

   task automatic wait_tick();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sample_tick) break;
      end
      chk("tick_seen", 32'(sample_tick), 32'd1);
   endtask

   task automatic next_angle(input logic [1:0] ch, output logic [31:0] val);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.angle_valid && bus.angle_ch == ch) begin
            found = 1'b1;
            break;
         end
      end
      chk("angle_seen", 32'(found), 32'd1);
      val = bus.angle_out;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] v;
      logic [31:0] exp_b [5];
      int          cyc;

      bus.cfg_valid = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_sel   = CFG_SEL_FTW;
      bus.cfg_data  = '0;
      bus.cfg_clr   = 1'b0;

      // Reset state
      #12;
      chk("rst_valid", 32'(bus.angle_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_ready", 32'(bus.cfg_ready), 32'd1);
      chk("rst_tick", 32'(sample_tick), 32'd0);
      chk("rst_angle", bus.angle_out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Wrap-around on ch0, burst shape, tick period
      div_val = 8'd5;
      cfg_write(2'd0, CFG_SEL_FTW, PHASE_INC, 1'b0);
      enable = 1'b1;
      wait_tick();
      @(negedge clk);
      chk("a_valid0", 32'(bus.angle_valid), 32'd1);
      chk("a_ch0", 32'(bus.angle_ch), 32'd0);
      chk("a_ang0", bus.angle_out, 32'h088F5C28);
      chk("a_busy0", 32'(busy), 32'd1);
      chk("a_ready0", 32'(bus.cfg_ready), 32'd0);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         chk("a_valid_k", 32'(bus.angle_valid), 32'd1);
         chk("a_ch_k", 32'(bus.angle_ch), 32'(k));
         chk("a_ang_k", bus.angle_out, 32'd0);
      end
      @(negedge clk);
      chk("a_idle_valid", 32'(bus.angle_valid), 32'd0);
      chk("a_idle_busy", 32'(busy), 32'd0);
      chk("a_idle_ready", 32'(bus.cfg_ready), 32'd1);
      chk("a_idle_ch_hold", 32'(bus.angle_ch), 32'd3);
      cyc = 5;
      for (int i = 0; i < 20 && !sample_tick; i++) begin
         @(negedge clk);
         cyc++;
      end
      chk("a_tick_period", 32'(cyc), 32'd6);
      next_angle(2'd0, v);
      chk("a_ang2", v, 32'h111EB850);
      for (int n = 3; n <= 30; n++) next_angle(2'd0, v);
      chk("a_wrap30", v, 32'h00CCCCB0);

      // Offset on ch1
      do_reset();
      div_val = 8'd5;
      cfg_write(2'd1, CFG_SEL_FTW, 32'h40000000, 1'b0);
      cfg_write(2'd1, CFG_SEL_OFF, 32'h20000000, 1'b0);
      enable = 1'b1;
      exp_b[0] = 32'h60000000;
      exp_b[1] = 32'hA0000000;
      exp_b[2] = 32'hE0000000;
      exp_b[3] = 32'h20000000;
      exp_b[4] = 32'h60000000;
      for (int n = 0; n < 5; n++) begin
         next_angle(2'd1, v);
         chk("b_off_ang", v, exp_b[n]);
      end

      // Write coincident with the tick is held for the following burst
      do_reset();
      div_val = 8'd5;
      cfg_write(2'd0, CFG_SEL_FTW, 32'h00000010, 1'b0);
      enable = 1'b1;
      wait_tick();
      chk("c_ready_at_tick", 32'(bus.cfg_ready), 32'd1);
      bus.cfg_valid = 1'b1;
      bus.cfg_addr  = 2'd0;
      bus.cfg_sel   = CFG_SEL_FTW;
      bus.cfg_data  = 32'h00000100;
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      chk("c_ch_first", 32'(bus.angle_ch), 32'd0);
      chk("c_ang_old_ftw", bus.angle_out, 32'h00000010);
      next_angle(2'd0, v);
      chk("c_ang_new_ftw", v, 32'h00000110);
      next_angle(2'd0, v);
      chk("c_ang_new_ftw2", v, 32'h00000210);

      // Accumulator clear on ch2
      do_reset();
      div_val = 8'd5;
      cfg_write(2'd2, CFG_SEL_FTW, 32'h01000000, 1'b0);
      cfg_write(2'd2, CFG_SEL_OFF, 32'h00000010, 1'b0);
      enable = 1'b1;
      for (int n = 1; n <= 10; n++) next_angle(2'd2, v);
      chk("d_pre_clear", v, 32'h0A000010);
      @(negedge clk);
      @(negedge clk);
      chk("d_no_tick_at_write", 32'(sample_tick), 32'd0);
      cfg_write(2'd2, CFG_SEL_FTW, 32'h01000000, 1'b1);
      next_angle(2'd2, v);
      chk("d_after_clear", v, 32'h01000010);
      next_angle(2'd2, v);
      chk("d_after_clear2", v, 32'h02000010);

      // Overrun with div_val = 1: back-to-back bursts, dropped mid-burst ticks
      do_reset();
      div_val = 8'd1;
      cfg_write(2'd0, CFG_SEL_FTW, 32'h00000001, 1'b0);
      cfg_write(2'd1, CFG_SEL_FTW, 32'h00000100, 1'b0);
      enable = 1'b1;
      wait_tick();
      chk("e_ovr_before", 32'(overrun), 32'd0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("e_burst_vc", {30'd0, bus.angle_valid, 1'b0} | 32'(bus.angle_ch),
             {30'd0, 1'b1, 1'b0} | 32'(i % 4));
         if (i == 1) chk("e_ovr_not_yet", 32'(overrun), 32'd0);
         if (i == 2) chk("e_ovr_set", 32'(overrun), 32'd1);
         if (i % 4 == 0) chk("e_ch0_ang", bus.angle_out, 32'(i / 4 + 1));
      end
      chk("e_ovr_sticky", 32'(overrun), 32'd1);

      // Reset asserted during burst cycle k = 1
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.angle_valid && bus.angle_ch == 2'd1) break;
      end
      chk("f_in_k1", 32'(bus.angle_ch), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("f_rst_valid", 32'(bus.angle_valid), 32'd0);
      chk("f_rst_busy", 32'(busy), 32'd0);
      chk("f_rst_overrun", 32'(overrun), 32'd0);
      chk("f_rst_angle", bus.angle_out, 32'd0);
      chk("f_rst_ready", 32'(bus.cfg_ready), 32'd1);
      enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      div_val = 8'd5;
      cfg_write(2'd0, CFG_SEL_FTW, 32'h00000001, 1'b0);
      cfg_write(2'd1, CFG_SEL_FTW, 32'h00000100, 1'b0);
      enable = 1'b1;
      next_angle(2'd0, v);
      chk("f_restart_ch0", v, 32'h00000001);
      next_angle(2'd1, v);
      chk("f_restart_ch1", v, 32'h00000100);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule : tb_nco_phase_seq
